// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;
   localparam int INSTR_W = 9;
   localparam int PC_W    = 16;
   localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 9'h1FF;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_FETCH = 2'd1,
      SEQ_EXEC  = 2'd2,
      SEQ_HALT  = 2'd3
   } seq_state_e;
endpackage

// File: rtl/fetch_sequencer_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign q = cnt_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, fetches one ROM word per instruction into the IR,
// waits for the datapath to finish it, then steps or branches.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [PC_W-1:0]    START_PC   = 16'h0000,
   parameter logic [PC_W-1:0]    PROG_LEN   = 16'd55,
   parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               ex_done,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] ir_out,
   output logic               ir_valid,
   output logic               busy,
   output logic               done,
   output logic               overrun,
   output logic [15:0]        retired_cnt
);
   seq_state_e         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               ir_valid_q, ir_valid_d;
   logic               overrun_q, overrun_d;
   logic               retire;
   logic               cnt_clr;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = 1'b0;
      overrun_d  = overrun_q;
      retire     = 1'b0;
      cnt_clr    = 1'b0;
      case (state_q)
         SEQ_IDLE, SEQ_HALT: begin
            if (start) begin
               pc_d      = START_PC;
               overrun_d = 1'b0;
               cnt_clr   = 1'b1;
               state_d   = SEQ_FETCH;
            end
         end
         SEQ_FETCH: begin
            // Out-of-range PC stops the program; the ROM word is not looked at.
            if (pc_q >= PROG_LEN) begin
               overrun_d = 1'b1;
               state_d   = SEQ_HALT;
            end else begin
               ir_d = instr_in;
               if (instr_in == HALT_INSTR) begin
                  state_d = SEQ_HALT;
               end else begin
                  ir_valid_d = 1'b1;
                  state_d    = SEQ_EXEC;
               end
            end
         end
         SEQ_EXEC: begin
            if (ex_done) begin
               pc_d    = branch_taken ? branch_target : pc_q + 16'd1;
               retire  = 1'b1;
               state_d = SEQ_FETCH;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEQ_IDLE;
         pc_q       <= START_PC;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   sat_counter #(.W(16)) u_retire (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire),
      .clr   (cnt_clr),
      .q     (retired_cnt)
   );

   assign pc_out   = pc_q;
   assign ir_out   = ir_q;
   assign ir_valid = ir_valid_q;
   assign busy     = (state_q == SEQ_FETCH) || (state_q == SEQ_EXEC);
   assign done     = (state_q == SEQ_HALT);
   assign overrun  = overrun_q;
endmodule
